mmio_bus_bridge: RTL and testbench
==================================

// Module: mmio_bus_bridge
// PURPOSE
//  Parametrised, sequential successor to the single-cycle CPU/peripheral bridge. Decodes each CPU
//  data-side access against N_SLV address windows and forwards it to the selected slave.
//  Waits on that slave's ready, returns registered read data, and flags unmapped or timed-out
//  accesses as bus errors. Sits between the pipeline's MEM stage and DM/TC1/TC2/interrupt-generator.
// PARAMETERS
//  N_SLV      4                                          number of slave windows
//  SLV_BASE   {32'h7F20,32'h7F10,32'h7F00,32'h0000}      packed 32*N_SLV, window i base (slot i = bits 32i+:32)
//  SLV_LIMIT  {32'h7F23,32'h7F1B,32'h7F0B,32'h2FFF}      packed 32*N_SLV, window i inclusive limit
//  TIMEOUT    16                                         max cycles in ACCESS before bus error (>=2)
// PORTS
//  clk        in   1          system clock
//  reset      in   1          synchronous, active-high reset
//  cpu_req    in   1          access request; CPU holds addr/wdata/byteen stable until cpu_ack
//  cpu_addr   in   32         byte address
//  cpu_wdata  in   32         write data
//  cpu_byteen in   4          byte enables; 0 = read, nonzero = write
//  cpu_ack    out  1          one-cycle completion pulse
//  cpu_rdata  out  32         read data, valid while cpu_ack
//  cpu_err    out  1          bus error, valid while cpu_ack
//  err_addr   out  32         address of most recent faulting access
//  err_cnt    out  8          saturating count of bus errors
//  s_req      out  N_SLV      one-hot per-slave request
//  s_addr     out  32         latched address, shared by all slaves
//  s_wdata    out  32         latched write data, shared
//  s_byteen   out  4          latched byte enables; forced 0 when no s_req is high
//  s_rdata    in   32*N_SLV   packed per-slave read data
//  s_ready    in   N_SLV      per-slave completion
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; timeout counter 0.
//  FSM IDLE/ACCESS/RESP; cpu_req is sampled only in IDLE.
//  IDLE: on cpu_req, latch addr/wdata/byteen and decode.
//   - Hit: window i matches when SLV_BASE[i] <= addr <= SLV_LIMIT[i]. On overlap the lowest index wins.
//     Latch idx, clear the counter, go to ACCESS.
//   - Miss: latch err_addr, increment err_cnt, set the error flag, go to RESP.
//  ACCESS: s_req[idx]=1.
//   - If s_ready[idx]: capture s_rdata[idx] (zero for writes), go to RESP with err=0.
//   - Else if counter == TIMEOUT-1: drop s_req, latch err_addr, increment err_cnt, go to RESP with err=1 and rdata=0.
//   - Otherwise increment the counter.
//   - s_ready arriving on the timeout cycle wins: no error.
//   - s_ready from a non-selected slave is ignored.
//  RESP: cpu_ack=1 for exactly one cycle with the registered rdata/err, then go to IDLE.
//  Latency: a request in cycle 0 raises s_req in cycle 1. With a zero-wait slave, ack comes in cycle 2.
//   A miss acks in cycle 1. Back-to-back: the next request is sampled at the earliest in the cycle after ack.
//  err_cnt saturates at 8'hFF.
//  Reset mid-access: s_req drops the next cycle; no ack is emitted; the in-flight access is abandoned.
//  Read data is muxed by the latched idx only, so each slave's data always returns from that slave.
// STRUCTURE
//  Shared include: state encodings (S_IDLE/S_ACCESS/S_RESP) and the default window base/limit macros
//   (DM, TC1, TC2, interrupt generator).
//  Sub-module mmio_addr_decode: combinational, parametrised by N_SLV/SLV_BASE/SLV_LIMIT.
//   Outputs: hit, idx ($clog2(N_SLV) bits), one-hot onehot.
//  Top module: FSM, latches, timeout counter, error logging, rdata register.
// TESTING
//  1. Read 0x0000_0010, DM ready at once, s_rdata[0]=32'hDEAD_BEEF
//     -> s_req=4'b0001 in cycle 1; ack in cycle 2 with rdata=DEADBEEF, err=0.
//  2. Write 0x7F14 (byteen=4'hF, data 5), TC2 ready after 3 cycles
//     -> s_req=4'b0100 held 4 cycles; s_byteen=F; TC1 sees no request; ack err=0.
//  3. Read 0x7F14 with s_rdata[1]=1, s_rdata[2]=2 -> rdata=2 (data from TC2, not TC1).
//  4. Access to 0x0000_5000 -> no s_req; ack in cycle 1 with err=1; err_addr=0x5000; err_cnt=1.
//  5. Slave never ready, TIMEOUT=16 -> s_req high for 16 cycles, then ack err=1, rdata=0.
//     Variant: ready on the 16th cycle -> err=0.
//  6. reset pulse while in ACCESS -> s_req=0 the next cycle, no ack, err_cnt=0.
//     A subsequent DM read completes normally.

Source files
------------

// File: rtl/mmio_bus_bridge_pkg.sv
// Shared definitions for the MMIO bus bridge: FSM states, default slave windows
// (DM, TC1, TC2, interrupt generator) and a small width helper.
package mmio_bus_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT  = 32'h0000_2FFF;
  localparam logic [31:0] TC1_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TC1_LIMIT = 32'h0000_7F0B;
  localparam logic [31:0] TC2_BASE  = 32'h0000_7F10;
  localparam logic [31:0] TC2_LIMIT = 32'h0000_7F1B;
  localparam logic [31:0] IG_BASE   = 32'h0000_7F20;
  localparam logic [31:0] IG_LIMIT  = 32'h0000_7F23;

  localparam int unsigned DEF_N_SLV = 4;
  localparam logic [32*DEF_N_SLV-1:0] DEF_SLV_BASE  = {IG_BASE,  TC2_BASE,  TC1_BASE,  DM_BASE};
  localparam logic [32*DEF_N_SLV-1:0] DEF_SLV_LIMIT = {IG_LIMIT, TC2_LIMIT, TC1_LIMIT, DM_LIMIT};

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational window decoder: reports whether an address falls in any slave
// window, and which one (lowest index wins on overlap).
module mmio_addr_decode
  import mmio_bus_bridge_pkg::*;
#(
  parameter int unsigned             N_SLV     = DEF_N_SLV,
  parameter logic [32*N_SLV-1:0]     SLV_BASE  = DEF_SLV_BASE,
  parameter logic [32*N_SLV-1:0]     SLV_LIMIT = DEF_SLV_LIMIT,
  parameter int unsigned             IDX_W     = idx_width(N_SLV)
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx,
  output logic [N_SLV-1:0] onehot
);

  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    onehot = '0;
    // Scan from the highest window down so the lowest matching index is kept last.
    for (int unsigned i = N_SLV; i > 0; i--) begin
      if ((addr >= SLV_BASE[32*(i-1) +: 32]) && (addr <= SLV_LIMIT[32*(i-1) +: 32])) begin
        hit    = 1'b1;
        idx    = IDX_W'(i - 1);
        onehot = N_SLV'(1) << (i - 1);
      end
    end
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// Sequential CPU-to-peripheral bridge: decodes an access, forwards it to one slave,
// waits for ready with a timeout, and returns registered data or a bus error.
module mmio_bus_bridge
  import mmio_bus_bridge_pkg::*;
#(
  parameter int unsigned         N_SLV     = DEF_N_SLV,
  parameter logic [32*N_SLV-1:0] SLV_BASE  = DEF_SLV_BASE,
  parameter logic [32*N_SLV-1:0] SLV_LIMIT = DEF_SLV_LIMIT,
  parameter int unsigned         TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_byteen,
  output logic                 cpu_ack,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_err,
  output logic [31:0]          err_addr,
  output logic [7:0]           err_cnt,
  output logic [N_SLV-1:0]     s_req,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_byteen,
  input  logic [32*N_SLV-1:0]  s_rdata,
  input  logic [N_SLV-1:0]     s_ready
);

  localparam int unsigned IDX_W = idx_width(N_SLV);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q,    state_d;
  logic [31:0]      addr_q,     addr_d;
  logic [31:0]      wdata_q,    wdata_d;
  logic [3:0]       byteen_q,   byteen_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [N_SLV-1:0] sel_q,      sel_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [31:0]      rdata_q,    rdata_d;
  logic             err_q,      err_d;
  logic [31:0]      err_addr_q, err_addr_d;
  logic [7:0]       err_cnt_q,  err_cnt_d;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic [N_SLV-1:0] dec_onehot;
  logic             sel_ready;
  logic [31:0]      sel_rdata;
  logic [7:0]       err_cnt_inc;

  mmio_addr_decode #(
    .N_SLV     (N_SLV),
    .SLV_BASE  (SLV_BASE),
    .SLV_LIMIT (SLV_LIMIT),
    .IDX_W     (IDX_W)
  ) u_decode (
    .addr   (cpu_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  // Ready is qualified by the latched one-hot select; data by the latched index.
  assign sel_ready   = |(s_ready & sel_q);
  assign sel_rdata   = s_rdata[32*idx_q +: 32];
  assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    byteen_d   = byteen_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          byteen_d = cpu_byteen;
          rdata_d  = '0;
          if (dec_hit) begin
            idx_d   = dec_idx;
            sel_d   = dec_onehot;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end else begin
            err_addr_d = cpu_addr;
            err_cnt_d  = err_cnt_inc;
            err_d      = 1'b1;
            state_d    = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        if (sel_ready) begin
          rdata_d = (byteen_q == 4'h0) ? sel_rdata : '0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_addr_d = addr_q;
          err_cnt_d  = err_cnt_inc;
          rdata_d    = '0;
          err_d      = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      byteen_q   <= '0;
      idx_q      <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      byteen_q   <= byteen_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign cpu_ack   = (state_q == S_RESP);
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;
  assign s_req     = (state_q == S_ACCESS) ? sel_q : '0;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_byteen  = (|s_req) ? byteen_q : 4'h0;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Scoreboard bench for mmio_bus_bridge: expected responses are queued when an
// access is driven and checked when the bridge acknowledges.
module tb_mmio_bus_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_byteen;
  logic         cpu_ack;
  logic [31:0]  cpu_rdata;
  logic         cpu_err;
  logic [31:0]  err_addr;
  logic [7:0]   err_cnt;
  logic [3:0]   s_req;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_byteen;
  logic [127:0] s_rdata;
  logic [3:0]   s_ready;

  int unsigned  ready_dly [4];
  logic [3:0]   spur;
  int unsigned  wait_cnt;
  logic [32:0]  sb_q [$];
  int           n_cmp = 0;
  int           n_mis = 0;

  mmio_bus_bridge #(
    .N_SLV   (4),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byteen (cpu_byteen),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .err_addr   (err_addr),
    .err_cnt    (err_cnt),
    .s_req      (s_req),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_byteen   (s_byteen),
    .s_rdata    (s_rdata),
    .s_ready    (s_ready)
  );

  always #5 clk = ~clk;

  // Slave model: ready after ready_dly[i] cycles of continuous request, plus optional spurious ready.
  always @(posedge clk) begin
    if (|s_req) wait_cnt <= wait_cnt + 1;
    else        wait_cnt <= 0;
  end

  always_comb begin
    s_ready = '0;
    for (int i = 0; i < 4; i++)
      s_ready[i] = (s_req[i] && (wait_cnt == ready_dly[i])) || spur[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && cpu_ack) begin
      chk("ack_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        logic [32:0] e;
        e = sb_q.pop_front();
        chk("rdata", cpu_rdata, e[31:0]);
        chk("err", 32'(cpu_err), 32'(e[32]));
      end
    end
  end

  task automatic access(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                        input logic [3:0] exp_sreq, input int exp_hold, input int exp_lat);
    int   cyc;
    int   hold;
    logic seen;
    logic [3:0] sreq_or;
    @(negedge clk);
    sb_q.push_back({exp_err, exp_rd});
    cpu_addr   = a;
    cpu_wdata  = wd;
    cpu_byteen = be;
    cpu_req    = 1'b1;
    cyc = 0; hold = 0; seen = 1'b0; sreq_or = '0;
    while (!seen && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk({tag, "_sreq_c1"}, 32'(s_req), 32'(exp_sreq));
        chk({tag, "_byteen_c1"}, 32'(s_byteen), (exp_sreq != 4'h0) ? 32'(be) : 32'd0);
        if (exp_sreq != 4'h0) begin
          chk({tag, "_saddr"}, s_addr, a);
          chk({tag, "_swdata"}, s_wdata, wd);
        end
      end
      if (|s_req) hold++;
      sreq_or |= s_req;
      if (cpu_ack) seen = 1'b1;
    end
    cpu_req = 1'b0;
    chk({tag, "_acked"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_hold"}, 32'(hold), 32'(exp_hold));
    chk({tag, "_sreq_all"}, 32'(sreq_or), 32'(exp_sreq));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byteen = '0;
    s_rdata = '0; spur = '0;
    for (int i = 0; i < 4; i++) ready_dly[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_sreq", 32'(s_req), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    chk("rst_erraddr", err_addr, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_byteen", 32'(s_byteen), 32'd0);
    reset = 1'b0;

    // Zero-wait DM read
    s_rdata[31:0] = 32'hDEAD_BEEF;
    access("rd_dm", 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 4'b0001, 1, 2);
    // TC2 write, ready after 3 cycles
    s_rdata[95:64] = 32'hCAFE_0002;
    ready_dly[2] = 3;
    access("wr_tc2", 32'h7F14, 32'h5, 4'hF, 32'h0, 1'b0, 4'b0100, 4, 5);
    // TC2 read while TC1 drives data and a spurious ready
    s_rdata[63:32] = 32'h1; s_rdata[95:64] = 32'h2; spur[1] = 1'b1; ready_dly[2] = 2;
    access("rd_tc2", 32'h7F14, 32'h0, 4'h0, 32'h2, 1'b0, 4'b0100, 3, 4);
    spur = '0;
    // Unmapped access
    access("miss", 32'h5000, 32'h0, 4'h0, 32'h0, 1'b1, 4'b0000, 0, 1);
    chk("miss_erraddr", err_addr, 32'h5000);
    chk("miss_errcnt", 32'(err_cnt), 32'd1);
    // Timeout, then ready on the last allowed cycle
    ready_dly[1] = 100;
    access("tmo", 32'h7F00, 32'h0, 4'h0, 32'h0, 1'b1, 4'b0010, 16, 17);
    chk("tmo_erraddr", err_addr, 32'h7F00);
    chk("tmo_errcnt", 32'(err_cnt), 32'd2);
    ready_dly[1] = 15;
    access("tmo_edge", 32'h7F0B, 32'h0, 4'h0, 32'h1, 1'b0, 4'b0010, 16, 17);
    chk("tmo_edge_errcnt", 32'(err_cnt), 32'd2);
    // Window boundaries
    access("dm_top", 32'h2FFF, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 4'b0001, 1, 2);
    s_rdata[127:96] = 32'h33; ready_dly[3] = 1;
    access("ig_top", 32'h7F23, 32'h0, 4'h0, 32'h33, 1'b0, 4'b1000, 2, 3);
    access("gap_tc1", 32'h7F0C, 32'h0, 4'h0, 32'h0, 1'b1, 4'b0000, 0, 1);
    access("gap_dm", 32'h3000, 32'h0, 4'h0, 32'h0, 1'b1, 4'b0000, 0, 1);
    access("ig_over", 32'h7F24, 32'h0, 4'h0, 32'h0, 1'b1, 4'b0000, 0, 1);
    chk("gap_errcnt", 32'(err_cnt), 32'd5);
    chk("gap_erraddr", err_addr, 32'h7F24);
    // Partial write to DM returns zero data
    access("wr_dm", 32'h100, 32'hA5A5_A5A5, 4'h3, 32'h0, 1'b0, 4'b0001, 1, 2);
    // Saturation of the error counter
    for (int i = 0; i < 255; i++)
      access("sat", 32'h4000 + 32'(i), 32'h0, 4'h0, 32'h0, 1'b1, 4'b0000, 0, 1);
    chk("sat_errcnt", 32'(err_cnt), 32'hFF);
    chk("sat_erraddr", err_addr, 32'h40FE);
    // Reset while an access is in flight
    ready_dly[0] = 100;
    @(negedge clk);
    cpu_addr = 32'h20; cpu_byteen = 4'h0; cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_sreq_before", 32'(s_req), 32'b0001);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_sreq", 32'(s_req), 32'd0);
    chk("rst_mid_ack", 32'(cpu_ack), 32'd0);
    chk("rst_mid_errcnt", 32'(err_cnt), 32'd0);
    cpu_req = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_idle", 32'(s_req | {3'b0, cpu_ack}), 32'd0);
    ready_dly[0] = 0;
    access("rd_after_rst", 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 4'b0001, 1, 2);
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
